// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO. It owns the read pointer and the empty flag, and turns
// the 1-cycle memory read latency into a first-word-fall-through valid/ready stream.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]         rptr_bin_q,   rptr_bin_d;
  logic [PW-1:0]         rptr_gray_q,  rptr_gray_d;
  logic                  mem_vld_q,    mem_vld_d;
  logic [DATA_WIDTH-1:0] dout_q,       dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic [PW-1:0] wbin;
  logic          empty_c;
  logic          take;
  logic          out_free;
  logic          move;
  logic          rd_en_c;
  logic [PW-1:0] rptr_bin_inc;

  // Stage 1 is the memory output register (mem_vld_q), stage 2 is dout.
  // A new fetch starts only when stage 1 is empty or drains into stage 2 this cycle.
  // This keeps an unconsumed memory word from being overwritten.
  always_comb begin
    wbin         = gray2bin(wptr_gray_sync);
    empty_c      = (rptr_gray_q == wptr_gray_sync);
    take         = dout_valid_q & dout_ready;
    out_free     = ~dout_valid_q | take;
    move         = mem_vld_q & out_free;
    rd_en_c      = ~empty_c & (~mem_vld_q | move);
    rptr_bin_inc = rptr_bin_q + 1'b1;
  end

  always_comb begin
    rptr_bin_d   = rptr_bin_q;
    rptr_gray_d  = rptr_gray_q;
    mem_vld_d    = mem_vld_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (rd_en_c) begin
      rptr_bin_d  = rptr_bin_inc;
      rptr_gray_d = bin2gray(rptr_bin_inc);
    end

    if (rd_en_c) begin
      mem_vld_d = 1'b1;
    end else if (move) begin
      mem_vld_d = 1'b0;
    end

    if (move) begin
      dout_d       = mem_data;
      dout_valid_d = 1'b1;
    end else if (take) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      rptr_bin_q   <= '0;
      rptr_gray_q  <= '0;
      mem_vld_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rptr_bin_q   <= rptr_bin_d;
      rptr_gray_q  <= rptr_gray_d;
      mem_vld_q    <= mem_vld_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign rd_en      = rd_en_c;
  assign raddr      = rptr_bin_q[ADDR_WIDTH-1:0];
  assign rptr_gray  = rptr_gray_q;
  assign empty      = empty_c;
  assign rd_count   = wbin - rptr_bin_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with ADDR_WIDTH=3. A behavioural memory and a
// write-pointer driver supply the stimulus, and a queue scoreboard checks the output stream.
module tb_fifo_read_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk_rd = 1'b0;
  logic          rst_rd;
  logic [AW:0]   wptr_gray_sync;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic [DW-1:0] mem_data = '0;
  logic [AW:0]   rptr_gray;
  logic          empty;
  logic [AW:0]   rd_count;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_rd(clk_rd), .rst_rd(rst_rd), .wptr_gray_sync(wptr_gray_sync),
    .rd_en(rd_en), .raddr(raddr), .mem_data(mem_data), .rptr_gray(rptr_gray),
    .empty(empty), .rd_count(rd_count), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 clk_rd = ~clk_rd;

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk_rd) if (rd_en) mem_data <= mem[raddr];

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int rd_pulses, wraps, takes, gaps, last_take;
  logic [AW:0] wbin;
  logic [DW-1:0] exp_q [$];

  function automatic logic [AW:0] b2g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 1'b1;
    wptr_gray_sync = b2g(wbin);
  endtask

  task automatic clr_stats();
    rd_pulses = 0; wraps = 0; takes = 0; gaps = 0; last_take = 0;
  endtask

  // Values sampled here are the ones the next rising edge will act on.
  task automatic settle();
    #1;
    if (rd_en) begin
      rd_pulses++;
      if (raddr == 3'd7) wraps++;
    end
    if (dout_valid && dout_ready) begin
      if (takes > 0 && cyc != last_take + 1) gaps++;
      last_take = cyc;
      takes++;
      if (exp_q.size() == 0) chk("sb_extra_word", {24'd0, dout}, 32'hFFFF_FFFF);
      else chk("sb_dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic tick();
    @(negedge clk_rd);
    cyc++;
  endtask

  task automatic do_reset();
    rst_rd = 1'b1; wptr_gray_sync = '0; wbin = '0; dout_ready = 1'b0;
    exp_q.delete();
    settle(); tick(); settle(); tick();
    rst_rd = 1'b0;
  endtask

  initial begin
    rst_rd = 1'b1; wptr_gray_sync = '0; wbin = '0; dout_ready = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    clr_stats();
    @(negedge clk_rd);
    do_reset();

    // idle after reset
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("idle_empty", empty, 1);
      chk("idle_rd_en", rd_en, 0);
      chk("idle_dvalid", dout_valid, 0);
      chk("idle_rd_count", rd_count, 0);
      chk("idle_rptr_gray", rptr_gray, 0);
      tick();
    end

    // single word: latency check
    dout_ready = 1'b1;
    push_word(8'hA5);
    settle();
    chk("single_rd_en_N", rd_en, 1);
    chk("single_raddr_N", raddr, 0);
    chk("single_empty_N", empty, 0);
    tick();
    settle();
    chk("single_empty_N1", empty, 1);
    chk("single_rptr_gray", rptr_gray, 1);
    chk("single_dvalid_N1", dout_valid, 0);
    chk("single_rd_en_N1", rd_en, 0);
    tick();
    settle();
    chk("single_dvalid_N2", dout_valid, 1);
    chk("single_dout_N2", dout, 8'hA5);
    tick();
    settle();
    chk("single_dvalid_N3", dout_valid, 0);
    tick();

    // streaming 20 words with wrap-around
    do_reset();
    dout_ready = 1'b1;
    clr_stats();
    for (int i = 0; i < 20; i++) begin
      push_word(8'(i));
      settle(); tick();
    end
    for (int k = 0; k < 6; k++) begin settle(); tick(); end
    chk("stream_takes", takes, 20);
    chk("stream_gaps", gaps, 0);
    chk("stream_rd_pulses", rd_pulses, 20);
    chk("stream_raddr_wraps", wraps, 2);
    chk("stream_rptr_gray", rptr_gray, 4'h6);
    chk("stream_empty", empty, 1);
    chk("stream_q_left", exp_q.size(), 0);

    // backpressure: 8 words waiting, consumer stalled
    dout_ready = 1'b0;
    clr_stats();
    for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
    for (int k = 0; k < 6; k++) begin
      settle();
      if (k >= 2) chk("bp_dout_frozen", dout, 8'h40);
      tick();
    end
    settle();
    chk("bp_rd_pulses", rd_pulses, 2);
    chk("bp_rd_en_off", rd_en, 0);
    chk("bp_dvalid", dout_valid, 1);
    chk("bp_rd_count", rd_count, 6);
    tick();
    dout_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin settle(); tick(); end
    chk("bp_takes", takes, 8);
    chk("bp_gaps", gaps, 0);
    chk("bp_rd_pulses_total", rd_pulses, 8);
    chk("bp_q_left", exp_q.size(), 0);
    chk("bp_empty", empty, 1);

    // full memory: write pointer a whole lap ahead
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'h80 + 8'(i));
    dout_ready = 1'b1;
    settle();
    chk("full_wptr_gray", wptr_gray_sync, 4'hC);
    chk("full_empty", empty, 0);
    chk("full_rd_count", rd_count, 8);
    chk("full_rd_en", rd_en, 1);
    tick();
    for (int k = 0; k < 12; k++) begin settle(); tick(); end
    chk("full_drained_empty", empty, 1);
    chk("full_rptr_gray", rptr_gray, 4'hC);
    chk("full_q_left", exp_q.size(), 0);

    // reset in the middle of a stalled stream
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(8'h60 + 8'(i));
    for (int k = 0; k < 4; k++) begin settle(); tick(); end
    settle();
    chk("mid_pre_dvalid", dout_valid, 1);
    chk("mid_pre_rd_count", rd_count, 1);
    chk("mid_pre_dout", dout, 8'h60);
    rst_rd = 1'b1; wptr_gray_sync = '0; wbin = '0;
    exp_q.delete();
    tick();
    rst_rd = 1'b0;
    settle();
    chk("mid_post_dvalid", dout_valid, 0);
    chk("mid_post_rptr_gray", rptr_gray, 0);
    chk("mid_post_rd_en", rd_en, 0);
    chk("mid_post_empty", empty, 1);
    tick();
    dout_ready = 1'b1;
    push_word(8'h77);
    settle();
    chk("resume_rd_en", rd_en, 1);
    chk("resume_raddr", raddr, 0);
    tick();
    settle();
    chk("resume_dvalid_N1", dout_valid, 0);
    tick();
    settle();
    chk("resume_dvalid_N2", dout_valid, 1);
    chk("resume_dout", dout, 8'h77);
    tick();
    chk("resume_q_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
